alu_rr_scheduler: RTL and testbench

Shares the single 8-bit combinational ALU between two requesters (e.g. the control-unit datapath and an address/loop-counter unit) using round-robin arbitration. Each request is accepted with a valid/ready handshake and its operands and opcode are registered. The ALU is driven from those registers for one cycle and the result is held until the consumer accepts it. The block sits between the requesters and the ALU instance and owns the ALU's A, B and opcode inputs.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/alu_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU
// round-robin scheduler.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational: the pointer register
// lives in the parent, this block computes the grant and the next pointer.
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,       // requester favoured when both are valid
  input  logic       i_upd,       // a response is being retired this cycle
  input  logic       i_resp_id,   // owner of the retiring response
  output logic [1:0] o_grant,     // one-hot, only for a valid requester
  output logic       o_gnt_id,
  output logic       o_any,
  output logic       o_ptr_next
);

  // Grant selection: a lone valid requester wins, ties go to the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    o_gnt_id = 1'b0;
    case (i_valid)
      2'b01:   o_gnt_id = 1'b0;
      2'b10:   o_gnt_id = 1'b1;
      2'b11:   o_gnt_id = i_ptr;
      default: o_gnt_id = 1'b0;
    endcase
  end

  assign o_any      = |i_valid;
  assign o_grant    = o_any ? (o_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  // After serving a requester, favour the other one next time.
  assign o_ptr_next = i_upd ? ~i_resp_id : i_ptr;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two
// requesters: IDLE accepts a request, EXEC drives the ALU for one cycle,
// RESP holds the result until the consumer takes it.
// Optional: define ALU_ZERO_FLAG_EN to add the registered resp_zero output.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic              busy
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic              resp_zero
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_ptr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_id;
  logic              w_accept;
  logic              w_retire;
  logic [1:0]        w_grant;
  logic              w_gnt_id;
  logic              w_any;
  logic              w_ptr_next;
  logic              w_idle;

  rr_arbiter2 u_arb (
    .i_valid    ({req1_valid, req0_valid}),
    .i_ptr      (r_ptr),
    .i_upd      (w_retire),
    .i_resp_id  (r_resp_id),
    .o_grant    (w_grant),
    .o_gnt_id   (w_gnt_id),
    .o_any      (w_any),
    .o_ptr_next (w_ptr_next)
  );

  assign w_idle = (r_state == S_IDLE);

  // Next-state logic and the accept/retire strobes that follow from it.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: w_state_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_resp_data <= '0;
      r_resp_id   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_accept) begin
        r_a       <= w_gnt_id ? req1_a  : req0_a;
        r_b       <= w_gnt_id ? req1_b  : req0_b;
        r_op      <= w_gnt_id ? req1_op : req0_op;
        r_resp_id <= w_gnt_id;
      end
      if (r_state == S_EXEC) begin
        r_resp_data <= alu_result;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic r_resp_zero;

  // Zero flag captured with the result so it stays aligned with resp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_zero <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_resp_zero <= (alu_result == '0);
    end
  end

  assign resp_zero = r_resp_zero;
`endif

  // The ALU sees the operand registers directly, so its inputs simply hold
  // their last values outside EXEC.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = ~w_idle;
  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler with a behavioural ALU model.
// Build with +define+ALU_ZERO_FLAG_EN to also check resp_zero.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       resp_valid, resp_id, resp_ready, busy;
  logic [7:0] resp_data;
`ifdef ALU_ZERO_FLAG_EN
  logic       resp_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .resp_zero  (resp_zero)
`endif
  );

  // Stand-in for the shared ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
    req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;
    step();
    rst = 1'b0;
  endtask

  // Checks that every output sits at its reset value.
  task automatic expect_reset_outputs(input string tag);
    checks++;
    if ({resp_valid, busy, req0_ready, req1_ready, resp_id} !== 5'b0) begin
      errors++;
      $display("FAIL %s_ctrl got valid=%b busy=%b rdy0=%b rdy1=%b id=%b exp all 0",
               tag, resp_valid, busy, req0_ready, req1_ready, resp_id);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, resp_data} !== 27'h0) begin
      errors++;
      $display("FAIL %s_data got a=%h b=%h op=%h data=%h exp all 0",
               tag, alu_a, alu_b, alu_op, resp_data);
    end
`ifdef ALU_ZERO_FLAG_EN
    checks++;
    if (resp_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s_zero got %b exp 0", tag, resp_zero);
    end
`endif
  endtask

  // One lone request through IDLE -> EXEC -> RESP -> IDLE with exact timing.
  task automatic run_single(input logic id, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s_ready got %b%b exp %b", tag, req1_ready, req0_ready,
               id ? 2'b10 : 2'b01);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_exec got valid=%b busy=%b exp 0/1", tag, resp_valid, busy);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp || resp_id !== id) begin
      errors++;
      $display("FAIL %s_resp got v=%b data=%h id=%b exp 1/%h/%b",
               tag, resp_valid, resp_data, resp_id, exp, id);
    end
`ifdef ALU_ZERO_FLAG_EN
    checks++;
    if (resp_zero !== (exp == 8'h00)) begin
      errors++;
      $display("FAIL %s_zero got %b exp %b", tag, resp_zero, exp == 8'h00);
    end
`endif
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got valid=%b busy=%b exp 0/0", tag, resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step();
    expect_reset_outputs("reset");
  endtask

  task automatic test_single();
    run_single(1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, "single_add");
  endtask

  task automatic test_contention();
    logic exp_id;
    logic [7:0] exp_data;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h05; req0_b = 8'h07;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 8'hF0; req1_b = 8'h0F;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = k[0];
      exp_data = exp_id ? 8'hFF : 8'hFE;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contend_grant%0d got %b%b exp id %b", k, req1_ready,
                 req0_ready, exp_id);
      end
      step();
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL contend_exec_ready%0d got %b%b exp 00", k, req1_ready, req0_ready);
      end
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== exp_data
          || {req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL contend_resp%0d got v=%b id=%b data=%h rdy=%b%b exp 1/%b/%h/00",
                 k, resp_valid, resp_id, resp_data, req1_ready, req0_ready,
                 exp_id, exp_data);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 8'h3C; req1_b = 8'h0F;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01;
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h0C || resp_id !== 1'b1
          || {req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL stall%0d got v=%b data=%h id=%b rdy=%b%b exp 1/0c/1/00",
                 k, resp_valid, resp_data, resp_id, req1_ready, req0_ready);
      end
      step();
    end
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got valid=%b busy=%b exp 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_illegal_and_wrap();
    do_reset();
    run_single(1'b0, 3'b111, 8'h55, 8'h00, 8'h00, "illegal_op");
    run_single(1'b0, 3'b000, 8'hFF, 8'h02, 8'h01, "wrap_add");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    // Leaves the pointer at 1 so a later tie proves reset cleared it.
    run_single(1'b0, 3'b000, 8'h01, 8'h01, 8'h02, "mid_pre");
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h02;
    step();
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_busy got %b exp 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_reset_outputs("rst_in_exec");
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 8'hAA; req1_b = 8'h55;
    step();
    req1_valid = 1'b0;
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hFF || resp_id !== 1'b1) begin
      errors++;
      $display("FAIL mid_resp got v=%b data=%h id=%b exp 1/ff/1",
               resp_valid, resp_data, resp_id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_reset_outputs("rst_in_resp");
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_ptr_cleared got %b%b exp 01", req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_valid_withdrawn();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b011; req0_a = 8'h50; req0_b = 8'h05;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h11; req1_b = 8'h22;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL wd_exec_ready1 got %b exp 0", req1_ready);
    end
    step();
    checks++;
    if (req1_ready !== 1'b0 || resp_data !== 8'h55 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL wd_resp got rdy1=%b data=%h id=%b exp 0/55/0",
               req1_ready, resp_data, resp_id);
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (req1_ready !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL wd_idle%0d got rdy1=%b valid=%b busy=%b exp 0/0/0",
                 k, req1_ready, resp_valid, busy);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_illegal_and_wrap();
    test_reset_mid_op();
    test_valid_withdrawn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
